// File: rtl/pull_ack_server_if.sv
// rtl/pull_ack_server_if.sv - request/ack and response-push bundle for pull_ack_server
// Purpose: groups the requester handshake, the response FIFO push port and the
//   server status outputs so a requester/bench and the server share one bundle.
// Signals:
//   request, active, lat_cfg   requester -> server transaction controls
//   push_valid, push_data      producer -> server response-word writes
//   push_ready                 server -> producer, FIFO not full
//   ack, rsp_data              server -> requester single-cycle answer
//   busy, fifo_count           server status
// Modports: master drives requests and pushes, slave is the server.
interface pull_ack_server_if #(
  parameter int LAT_W  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              request;
  logic              active;
  logic [LAT_W-1:0]  lat_cfg;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              ack;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output request, active, lat_cfg, push_valid, push_data,
    input  push_ready, ack, rsp_data, busy, fifo_count
  );

  modport slave (
    input  request, active, lat_cfg, push_valid, push_data,
    output push_ready, ack, rsp_data, busy, fifo_count
  );
endinterface

// File: rtl/pull_ack_server.sv
// rtl/pull_ack_server.sv - responder answering level-held requests with a one-cycle ack and FIFO word
// Purpose: accepts a transaction when request && active, waits lat_cfg cycles,
//   then pops the response FIFO head into rsp_data with a single-cycle ack.
//   Drops the transaction if active falls during the wait; stalls with cnt=0
//   while the FIFO is empty.
// Ports:
//   clk     single clock, rising edge
//   rst_n   synchronous active-low reset
//   bus     pull_ack_server_if.slave (request/active/lat_cfg, push port,
//           ack/rsp_data, busy, fifo_count)
//   served_count, stall_cycles   16-bit saturating counters, present only
//           when PULL_SERVER_STATS_EN is defined
// Optional feature macro: PULL_SERVER_STATS_EN
module pull_ack_server #(
  parameter int LAT_W  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pull_ack_server_if.slave bus
`ifdef PULL_SERVER_STATS_EN
  ,
  output logic [15:0]      served_count,
  output logic [15:0]      stall_cycles
`endif
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LAT, ACK, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  cnt, cnt_nxt;
  logic              ack_q, ack_nxt;
  logic [DATA_W-1:0] rsp_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push, do_pop;

  // Full/empty come from the registered count, so a word pushed this cycle
  // only becomes poppable on the following edge.
  assign bus.push_ready = (count != CNT_W'(DEPTH));
  assign do_push        = bus.push_valid && bus.push_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    do_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.request && bus.active) begin
          state_nxt = LAT;
          cnt_nxt   = bus.lat_cfg;
        end
      end
      LAT: begin
        if (!bus.active) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - LAT_W'(1);
        end else if (count != '0) begin
          do_pop    = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = RELEASE;
      // Wait for the requester to drop request so one transaction yields one ack.
      RELEASE: if (!bus.request) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ack_q  <= 1'b0;
      rsp_q  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack_q <= ack_nxt;
      if (do_pop) begin
        rsp_q  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= bus.push_data;
  end

  assign bus.ack        = ack_q;
  assign bus.rsp_data   = rsp_q;
  assign bus.busy       = (state != IDLE);
  assign bus.fifo_count = count;

`ifdef PULL_SERVER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      served_count <= '0;
      stall_cycles <= '0;
    end else begin
      if (ack_q && served_count != 16'hFFFF) served_count <= served_count + 16'd1;
      if (state == LAT && cnt == '0 && count == '0 && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pull_ack_server.sv
// tb/tb_pull_ack_server.sv - scoreboard bench for pull_ack_server
module tb_pull_ack_server;
  localparam int LAT_W  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pull_ack_server_if #(.LAT_W(LAT_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef PULL_SERVER_STATS_EN
  logic [15:0] served_count;
  logic [15:0] stall_cycles;
`endif

  pull_ack_server #(.LAT_W(LAT_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PULL_SERVER_STATS_EN
    ,
    .served_count (served_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // Reference model: words with the edge at which they were pushed, and the
  // expected ack responses with the edge number at which ack must appear.
  typedef struct {logic [7:0] data; int pedge;} word_t;
  typedef struct {logic [7:0] data; int cyc;} exp_t;

  word_t mq[$];
  exp_t  exp_q[$];
  exp_t  mon_e;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=ack rsp_data=%0h expected=no_ack (cycle %0d)",
                 bus.rsp_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
        check("ack_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    bus.push_valid = 1'b1;
    bus.push_data  = d;
    if (mq.size() < DEPTH) mq.push_back('{d, cyc + 1});
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic expect_head(input int e0, input int lat, output logic [7:0] d);
    word_t h;
    int    ac;
    h  = mq.pop_front();
    ac = e0 + lat + 1;
    if (h.pedge + 1 > ac) ac = h.pedge + 1;
    exp_q.push_back('{h.data, ac});
    d = h.data;
  endtask

  // One full requester transaction. sdly>0 pushes sdat so it is sampled at
  // edge e0+sdly (stall data when the FIFO is empty at accept).
  task automatic run_txn(input int lat, input int hold, input int sdly, input logic [7:0] sdat);
    int         e0, a, ex, n;
    logic [7:0] d;
    bit         queued;
    bus.request = 1'b1;
    bus.active  = 1'b1;
    bus.lat_cfg = 4'(lat);
    e0 = cyc + 1;
    queued = 1'b0;
    if (mq.size() != 0) begin
      expect_head(e0, lat, d);
      queued = 1'b1;
    end
    tick();
    bus.lat_cfg = 4'($urandom);
    if (sdly > 0) begin
      while (cyc < e0 + sdly - 1) tick();
      push_word(sdat);
    end
    if (!queued) expect_head(e0, lat, d);
    n = 0;
    while (!bus.ack && n < 64) begin
      tick();
      n++;
    end
    check("ack_seen", 32'(bus.ack), 32'd1);
    a = cyc;
    repeat (hold) tick();
    bus.request = 1'b0;
    bus.active  = 1'b0;
    ex = (a + hold + 1 > a + 2) ? a + hold + 1 : a + 2;
    while (cyc < ex - 1) tick();
    check("busy_release", 32'(bus.busy), 32'd1);
    tick();
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("rsp_hold", 32'(bus.rsp_data), 32'(d));
    check("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
    check("push_ready", 32'(bus.push_ready), 32'(mq.size() < DEPTH));
  endtask

  task automatic abort_txn(input int lat, input int dly);
    int c0;
    c0 = mq.size();
    bus.request = 1'b1;
    bus.active  = 1'b1;
    bus.lat_cfg = 4'(lat);
    tick();
    repeat (dly) tick();
    check("busy_abort_lat", 32'(bus.busy), 32'd1);
    bus.request = 1'b0;
    bus.active  = 1'b0;
    tick();
    check("busy_abort", 32'(bus.busy), 32'd0);
    repeat (lat + 4) tick();
    check("fifo_abort", 32'(bus.fifo_count), 32'(c0));
  endtask

  task automatic reset_in_lat();
    bus.request = 1'b1;
    bus.active  = 1'b1;
    bus.lat_cfg = 4'd4;
    repeat (3) tick();
    check("busy_pre_reset", 32'(bus.busy), 32'd1);
    rst_n          = 1'b0;
    bus.request    = 1'b0;
    bus.active     = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = 8'($urandom);
    tick();
    bus.push_valid = 1'b0;
    mq.delete();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("rst_push_ready", 32'(bus.push_ready), 32'd1);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int lat, hold;
    bus.request    = 1'b0;
    bus.active     = 1'b0;
    bus.lat_cfg    = '0;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    rst_n          = 1'b0;
    repeat (2) tick();
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("reset_push_ready", 32'(bus.push_ready), 32'd1);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    rst_n = 1'b1;
    tick();

    push_word(8'hA5);
    push_word(8'h3C);
    check("preload_count", 32'(bus.fifo_count), 32'd2);
    run_txn(3, 0, 0, 8'h00);
    run_txn(1, 0, 0, 8'h00);

    run_txn(0, 0, 5, 8'h77);

    push_word(8'h5A);
    run_txn(2, 4, 0, 8'h00);

    push_word(8'hC3);
    abort_txn(6, 2);

    while (mq.size() < DEPTH) push_word(8'($urandom));
    check("full_push_ready", 32'(bus.push_ready), 32'd0);
    check("full_count", 32'(bus.fifo_count), 32'(DEPTH));
    push_word(8'hEE);
    check("drop_count", 32'(bus.fifo_count), 32'(DEPTH));
    run_txn(1, 0, 0, 8'h00);
    run_txn(2, 1, 3, 8'($urandom));

    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      repeat ($urandom_range(0, 2)) if (mq.size() < DEPTH) push_word(8'($urandom));
      lat  = $urandom_range(0, 5);
      hold = $urandom_range(0, 3);
      if (mq.size() == 0) run_txn(lat, hold, $urandom_range(1, 6), 8'($urandom));
      else                run_txn(lat, hold, 0, 8'h00);
    end

    if (mq.size() == 0) push_word(8'h96);
    reset_in_lat();

    repeat (5) tick();
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
